mini_core_commit_checker: RTL and testbench
===========================================

Name: mini_core_commit_checker

Overview:
Synthesizable lock-step commit scoreboard for the mini_core tile environment. It accepts two retirement streams, one from the DUT and one from the rv32i reference model. Each stream is buffered in its own FIFO, and the heads are compared in order. The block replaces fixed-delay end-of-test with ebreak-driven completion plus an inactivity timeout, and reports pass/fail, mismatch count and the first failing PC.

Parameters:
XLEN, 32, width of PC and register data
DEPTH, 8, entries per commit FIFO (power of 2, >=2)
TIMEOUT_CYC, 1000, max cycles in RUN without a compare before timeout fail
MAX_ERR, 1, mismatches tolerated before entering FAIL (1 = stop on first)
CNT_W, 16, width of mismatch counter

Ports:
Clock  in  1  core clock
Rst  in  1  asynchronous, active-high reset
Enable  in  1  start checking; sampled in IDLE
DutValid  in  1  DUT retired an instruction this cycle
DutPc  in  XLEN  PC of retired instruction
DutInst  in  32  instruction word
DutRdWrEn  in  1  instruction writes rd
DutRd  in  5  destination register
DutRdData  in  XLEN  write-back data
DutReady  out  1  DUT FIFO not full (advisory, DUT not stalled)
RefValid/RefPc/RefInst/RefRdWrEn/RefRd/RefRdData  in  as Dut*  reference-model stream
RefReady  out  1  ref FIFO not full
Done  out  1  sticky; checker in PASS or FAIL
Pass  out  1  sticky; PASS reached
Fail  out  1  sticky; FAIL reached
FailCause  out  3  t_fail_cause of first failure
FailPc  out  XLEN  DUT PC of first failure (0 for timeout/overflow)
MismatchCnt  out  CNT_W  number of mismatching compares (saturating)
CommitCnt  out  32  number of compared commit pairs

Behaviour:
- Reset (async, Rst=1): FIFOs empty, state IDLE, all outputs 0 except DutReady=RefReady=1.
- FIFO push: on Valid=1 when not full, or when full and a pop occurs in the same cycle. Valid=1 while full with no same-cycle pop sets FailCause=OVERFLOW and enters FAIL; the entry is dropped.
- Pushes are accepted in every state except PASS/FAIL; there, pushes are ignored and no overflow is flagged.
- Compare fires when state=RUN and both FIFOs are non-empty. Both heads pop in the same cycle.
- Comparison result and counters are registered one cycle after the pop. Push-to-compare latency is 1 cycle minimum, so a same-cycle push on both sides into empty FIFOs gives a result 2 cycles later.
- Match rules:
  - PC, Inst and RdWrEn must be equal.
  - If RdWrEn=1 and Rd!=0, Rd and RdData must also be equal.
  - Rd/RdData are ignored when RdWrEn=0 or Rd=0.
- Cause priority: PC_MISMATCH > INST_MISMATCH > RD_MISMATCH > DATA_MISMATCH.
- On mismatch:
  - MismatchCnt increments, saturating at all-ones.
  - FailPc/FailCause latch on the first mismatch only.
  - When MismatchCnt reaches MAX_ERR, enter FAIL.
- CommitCnt increments on every compare (wraps).
- States:
  - IDLE: Enable=1 -> RUN.
  - RUN:
    - compared DUT head Inst == EBREAK_INST and it matched -> DRAIN
    - timeout counter == TIMEOUT_CYC-1 -> FAIL (cause TIMEOUT)
    - error limit reached -> FAIL
  - DRAIN: waits 2 cycles.
    - Any push during DRAIN -> FAIL (cause POST_EBREAK).
    - Otherwise -> PASS if MismatchCnt==0, else FAIL.
  - PASS/FAIL: terminal until reset; Enable is ignored.
- Timeout counter: clears on every compare and on entry to RUN; increments each RUN cycle otherwise.
- Simultaneous mismatch and timeout in the same cycle: the mismatch cause wins.
- Deasserting Enable mid-RUN has no effect.
- Reset mid-operation discards all state, including sticky flags.

Decomposition:
- common_pkg additions:
  - t_commit struct {pc, inst, rd_wr_en, rd, rd_data}
  - t_chk_state enum {IDLE, RUN, DRAIN, PASS, FAIL}
  - t_fail_cause enum {NONE=0, PC_MISMATCH, INST_MISMATCH, RD_MISMATCH, DATA_MISMATCH, TIMEOUT, OVERFLOW, POST_EBREAK}
  - EBREAK_INST = 32'h0010_0073
- Sub-module mini_commit_fifo: parametrised DEPTH x t_commit, registered storage, ptr+1 wrap, outputs full/empty/head, push-while-full-with-pop allowed. Instantiated twice.

Test Plan:
- Identical streams: 5 commits (pc 0x0,0x4,0x8,0xC,0x10; last inst 0x00100073) -> PASS after DRAIN, CommitCnt=5, MismatchCnt=0, FailCause=NONE.
- Ref leads DUT by 4 cycles on the same 6 commits, DEPTH=8 -> no overflow, compares begin when the DUT head arrives, PASS, CommitCnt=6.
- DUT commit 3 has RdData 0x55 vs ref 0x56 with rd=x5 -> FAIL, FailCause=DATA_MISMATCH, FailPc=0x8, MismatchCnt=1, result 1 cycle after pop.
- Data mismatch with rd=x0, all else equal, ending in ebreak -> PASS (x0 write ignored).
- Enable=1, no Valid for TIMEOUT_CYC=20 cycles -> FAIL with FailCause=TIMEOUT at cycle 20 after RUN entry, FailPc=0.
- DEPTH=2, 3 DUT pushes and no ref pushes -> third push gives FAIL (OVERFLOW). Then assert Rst mid-FAIL -> all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/mini_core_commit_checker_pkg.sv
// -----------------------------------------------------------------------------
// mini_core_commit_checker_pkg
// Shared types for the mini_core commit scoreboard: checker state, failure
// cause codes, the ebreak opcode that signals end-of-test, and the default
// (32-bit) commit record used by environment code.
// -----------------------------------------------------------------------------
package mini_core_commit_checker_pkg;

  // ebreak retiring on both streams (and matching) ends the test.
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } t_chk_state;

  typedef enum logic [2:0] {
    NONE          = 3'd0,
    PC_MISMATCH   = 3'd1,
    INST_MISMATCH = 3'd2,
    RD_MISMATCH   = 3'd3,
    DATA_MISMATCH = 3'd4,
    TIMEOUT       = 3'd5,
    OVERFLOW      = 3'd6,
    POST_EBREAK   = 3'd7
  } t_fail_cause;

  // Default-width commit record. The checker itself builds an XLEN-wide
  // record with the same field order.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rd_wr_en;
    logic [4:0]  rd;
    logic [31:0] rd_data;
  } t_commit;

endpackage

// File: rtl/mini_commit_fifo.sv
// -----------------------------------------------------------------------------
// mini_commit_fifo
// DEPTH-entry FIFO of packed commit records with registered storage and a
// combinational head view. A push into a full FIFO is accepted when a pop
// happens in the same cycle (the freed slot is reused).
// Ports:
//   clk, rst        clock, asynchronous active-high reset (pointers only)
//   push, push_data write request and record
//   pop             remove head (ignored when empty)
//   full, empty     occupancy flags
//   head            record at the read pointer
// -----------------------------------------------------------------------------
module mini_commit_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mini_core_commit_checker.sv
// -----------------------------------------------------------------------------
// mini_core_commit_checker
// Lock-step commit scoreboard. DUT and reference retirement streams are each
// buffered in a FIFO; while running, both heads are popped and compared
// together. A matched ebreak ends the test (after a 2-cycle quiet drain), an
// inactivity timeout or too many mismatches fail it.
// Ports:
//   Clock, Rst            clock, asynchronous active-high reset
//   Enable                start checking (sampled in IDLE)
//   Dut*/Ref*             retirement streams: Valid, Pc, Inst, RdWrEn, Rd, RdData
//   DutReady/RefReady     FIFO not full (advisory)
//   Done/Pass/Fail        sticky completion flags
//   FailCause, FailPc     cause and DUT PC of the first failure
//   MismatchCnt           saturating count of mismatching compares
//   CommitCnt             wrapping count of compared pairs
// -----------------------------------------------------------------------------
module mini_core_commit_checker
  import mini_core_commit_checker_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_ERR     = 1,
  parameter int CNT_W       = 16
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             Enable,
  input  logic             DutValid,
  input  logic [XLEN-1:0]  DutPc,
  input  logic [31:0]      DutInst,
  input  logic             DutRdWrEn,
  input  logic [4:0]       DutRd,
  input  logic [XLEN-1:0]  DutRdData,
  output logic             DutReady,
  input  logic             RefValid,
  input  logic [XLEN-1:0]  RefPc,
  input  logic [31:0]      RefInst,
  input  logic             RefRdWrEn,
  input  logic [4:0]       RefRd,
  input  logic [XLEN-1:0]  RefRdData,
  output logic             RefReady,
  output logic             Done,
  output logic             Pass,
  output logic             Fail,
  output logic [2:0]       FailCause,
  output logic [XLEN-1:0]  FailPc,
  output logic [CNT_W-1:0] MismatchCnt,
  output logic [31:0]      CommitCnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            rd_wr_en;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
  } t_entry;

  localparam int              EW        = $bits(t_entry);
  localparam int              TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LIM    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_ERR_C = CNT_W'(MAX_ERR);

  t_chk_state       state;
  t_chk_state       state_next;
  t_fail_cause      fail_cause;
  t_fail_cause      fail_evt;
  t_fail_cause      cmp_cause;
  logic [XLEN-1:0]  fail_pc;
  logic [CNT_W-1:0] mis_cnt;
  logic [CNT_W-1:0] mis_cnt_inc;
  logic [31:0]      commit_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             drain_cnt;

  t_entry dut_in, ref_in, dut_head, ref_head;
  logic   dut_full, dut_empty, ref_full, ref_empty;
  logic   accepting, fire, mismatch, rd_live;
  logic   dut_push, ref_push, dut_ovf, ref_ovf;
  logic   err_limit, ebreak_ok, timeout_hit;

  assign dut_in = '{pc: DutPc, inst: DutInst, rd_wr_en: DutRdWrEn, rd: DutRd, rd_data: DutRdData};
  assign ref_in = '{pc: RefPc, inst: RefInst, rd_wr_en: RefRdWrEn, rd: RefRd, rd_data: RefRdData};

  // Terminal states freeze the FIFOs so late traffic cannot flag overflow.
  assign accepting = (state != PASS) && (state != FAIL);
  assign fire      = (state == RUN) && !dut_empty && !ref_empty;
  assign dut_push  = accepting && DutValid && (!dut_full || fire);
  assign ref_push  = accepting && RefValid && (!ref_full || fire);
  assign dut_ovf   = accepting && DutValid && dut_full && !fire;
  assign ref_ovf   = accepting && RefValid && ref_full && !fire;

  mini_commit_fifo #(.W(EW), .DEPTH(DEPTH)) u_dut_fifo (
    .clk       (Clock),
    .rst       (Rst),
    .push      (dut_push),
    .push_data (dut_in),
    .pop       (fire),
    .full      (dut_full),
    .empty     (dut_empty),
    .head      (dut_head)
  );

  mini_commit_fifo #(.W(EW), .DEPTH(DEPTH)) u_ref_fifo (
    .clk       (Clock),
    .rst       (Rst),
    .push      (ref_push),
    .push_data (ref_in),
    .pop       (fire),
    .full      (ref_full),
    .empty     (ref_empty),
    .head      (ref_head)
  );

  // Head comparison in priority order. Writes to x0 carry no architectural
  // state, so rd/data only matter when a nonzero register is written.
  always_comb begin
    cmp_cause = NONE;
    rd_live   = dut_head.rd_wr_en && ((dut_head.rd != 5'd0) || (ref_head.rd != 5'd0));
    if (dut_head.pc != ref_head.pc) begin
      cmp_cause = PC_MISMATCH;
    end else if (dut_head.inst != ref_head.inst) begin
      cmp_cause = INST_MISMATCH;
    end else if (dut_head.rd_wr_en != ref_head.rd_wr_en) begin
      cmp_cause = RD_MISMATCH;
    end else if (rd_live && (dut_head.rd != ref_head.rd)) begin
      cmp_cause = RD_MISMATCH;
    end else if (rd_live && (dut_head.rd_data != ref_head.rd_data)) begin
      cmp_cause = DATA_MISMATCH;
    end
  end

  assign mismatch    = (cmp_cause != NONE);
  assign mis_cnt_inc = (mis_cnt == '1) ? mis_cnt : mis_cnt + CNT_W'(1);
  assign err_limit   = fire && mismatch && (mis_cnt_inc >= MAX_ERR_C);
  assign ebreak_ok   = fire && !mismatch && (dut_head.inst == EBREAK_INST);
  assign timeout_hit = (state == RUN) && !fire && (to_cnt == TO_LIM);

  always_comb begin
    state_next = state;
    fail_evt   = NONE;
    case (state)
      IDLE: begin
        if (dut_ovf || ref_ovf) begin
          state_next = FAIL;
          fail_evt   = OVERFLOW;
        end else if (Enable) begin
          state_next = RUN;
        end
      end
      RUN: begin
        // A mismatch hitting the limit wins over everything else this cycle;
        // its cause is latched by the compare path below.
        if (err_limit) begin
          state_next = FAIL;
        end else if (dut_ovf || ref_ovf) begin
          state_next = FAIL;
          fail_evt   = OVERFLOW;
        end else if (ebreak_ok) begin
          state_next = DRAIN;
        end else if (timeout_hit) begin
          state_next = FAIL;
          fail_evt   = TIMEOUT;
        end
      end
      DRAIN: begin
        if (DutValid || RefValid) begin
          state_next = FAIL;
          fail_evt   = POST_EBREAK;
        end else if (drain_cnt) begin
          state_next = (mis_cnt == '0) ? PASS : FAIL;
        end
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      fail_cause <= NONE;
      fail_pc    <= '0;
      mis_cnt    <= '0;
      commit_cnt <= '0;
      to_cnt     <= '0;
      drain_cnt  <= 1'b0;
    end else begin
      state <= state_next;

      if (fire) begin
        commit_cnt <= commit_cnt + 32'd1;
        if (mismatch) begin
          mis_cnt <= mis_cnt_inc;
        end
      end

      // Only the first failure of any kind is recorded.
      if (fire && mismatch && (fail_cause == NONE)) begin
        fail_cause <= cmp_cause;
        fail_pc    <= dut_head.pc;
      end else if ((fail_evt != NONE) && (fail_cause == NONE)) begin
        fail_cause <= fail_evt;
      end

      if ((state != RUN) || fire) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_LIM) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  assign DutReady    = !dut_full;
  assign RefReady    = !ref_full;
  assign Done        = (state == PASS) || (state == FAIL);
  assign Pass        = (state == PASS);
  assign Fail        = (state == FAIL);
  assign FailCause   = fail_cause;
  assign FailPc      = fail_pc;
  assign MismatchCnt = mis_cnt;
  assign CommitCnt   = commit_cnt;

endmodule

// File: tb/tb_mini_core_commit_checker.sv
// -----------------------------------------------------------------------------
// tb_mini_core_commit_checker
// Directed scenarios plus randomized commit streams for the commit checker.
// The reference model walks the two commit queues pair by pair and predicts
// the outcome from the matching rules. A second instance (DEPTH=2) covers
// overflow and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_mini_core_commit_checker;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam int C_NONE = 0, C_PC = 1, C_INST = 2, C_RD = 3, C_DATA = 4;
  localparam int C_TO = 5, C_OVF = 6, C_POST = 7;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
  } rec_t;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        rst, en, d_v, r_v;
  logic [31:0] d_pc, d_inst, d_data, r_pc, r_inst, r_data;
  logic        d_wr, r_wr;
  logic [4:0]  d_rd, r_rd;
  logic        d_rdy, r_rdy, done, pass, fail;
  logic [2:0]  cause;
  logic [31:0] fpc, commits;
  logic [15:0] mis;

  logic        rst2, en2, dv2, rv2;
  logic        d_rdy2, r_rdy2, done2, pass2, fail2;
  logic [2:0]  cause2;
  logic [31:0] fpc2, commits2;
  logic [15:0] mis2;

  int vectors = 0;
  int miscompares = 0;

  rec_t dq[$];
  rec_t rq[$];

  mini_core_commit_checker #(.XLEN(32), .DEPTH(8), .TIMEOUT_CYC(20), .MAX_ERR(1), .CNT_W(16)) u_dut (
    .Clock(Clock), .Rst(rst), .Enable(en),
    .DutValid(d_v), .DutPc(d_pc), .DutInst(d_inst), .DutRdWrEn(d_wr), .DutRd(d_rd), .DutRdData(d_data),
    .DutReady(d_rdy),
    .RefValid(r_v), .RefPc(r_pc), .RefInst(r_inst), .RefRdWrEn(r_wr), .RefRd(r_rd), .RefRdData(r_data),
    .RefReady(r_rdy),
    .Done(done), .Pass(pass), .Fail(fail), .FailCause(cause), .FailPc(fpc),
    .MismatchCnt(mis), .CommitCnt(commits)
  );

  mini_core_commit_checker #(.XLEN(32), .DEPTH(2), .TIMEOUT_CYC(1000), .MAX_ERR(1), .CNT_W(16)) u_ovf (
    .Clock(Clock), .Rst(rst2), .Enable(en2),
    .DutValid(dv2), .DutPc(d_pc), .DutInst(d_inst), .DutRdWrEn(d_wr), .DutRd(d_rd), .DutRdData(d_data),
    .DutReady(d_rdy2),
    .RefValid(rv2), .RefPc(r_pc), .RefInst(r_inst), .RefRdWrEn(r_wr), .RefRd(r_rd), .RefRdData(r_data),
    .RefReady(r_rdy2),
    .Done(done2), .Pass(pass2), .Fail(fail2), .FailCause(cause2), .FailPc(fpc2),
    .MismatchCnt(mis2), .CommitCnt(commits2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic put_d(input rec_t c);
    d_v = 1'b1; d_pc = c.pc; d_inst = c.inst; d_wr = c.wr; d_rd = c.rd; d_data = c.data;
  endtask

  task automatic put_r(input rec_t c);
    r_v = 1'b1; r_pc = c.pc; r_inst = c.inst; r_wr = c.wr; r_rd = c.rd; r_data = c.data;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; d_v = 1'b0; r_v = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] inst,
                              input logic wr, input logic [4:0] rd, input logic [31:0] data);
    rec_t c;
    c.pc = pc; c.inst = inst; c.wr = wr; c.rd = rd; c.data = data;
    return c;
  endfunction

  // Plain in-order stream: pc = 4*i, last entry is ebreak.
  task automatic build_stream(input int n);
    dq.delete();
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) dq.push_back(mk(32'(4 * i), EBREAK, 1'b0, 5'd0, 32'd0));
      else            dq.push_back(mk(32'(4 * i), 32'h0000_0013 + 32'(i << 7), 1'b1, 5'(i + 1), 32'(100 + i)));
    end
    rq = dq;
  endtask

  // mode 0: lock-step, 1: reference leads by 4 cycles, 2: random pacing.
  task automatic drive(input int mode);
    int di = 0, ri = 0, t = 0, dgap = 0, rgap = 0;
    logic pd, pr;
    en = 1'b1;
    while (di < dq.size() || ri < rq.size()) begin
      case (mode)
        0: begin pd = 1'b1; pr = 1'b1; end
        1: begin pd = (t >= 4); pr = 1'b1; end
        default: begin
          pd = ($urandom_range(0, 1) == 1) || (dgap >= 3);
          pr = ($urandom_range(0, 1) == 1) || (rgap >= 3);
          if (di - ri >= 4) pd = 1'b0;
          if (ri - di >= 4) pr = 1'b0;
        end
      endcase
      pd = pd && (di < dq.size());
      pr = pr && (ri < rq.size());
      d_v = 1'b0; r_v = 1'b0;
      if (pd) begin put_d(dq[di]); di++; dgap = 0; end else dgap++;
      if (pr) begin put_r(rq[ri]); ri++; rgap = 0; end else rgap++;
      step();
      t++;
    end
    d_v = 1'b0; r_v = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && !done; k++) step();
  endtask

  // Outcome predicted from the rules: walk pairs in order; the first
  // mismatch fails (MAX_ERR=1), a matching ebreak passes.
  task automatic predict(output int e_pass, output int e_cause, output logic [31:0] e_pc,
                         output int e_mis, output int e_commits);
    e_pass = 0; e_cause = C_NONE; e_pc = 32'd0; e_mis = 0; e_commits = 0;
    for (int i = 0; i < dq.size(); i++) begin
      rec_t a, b;
      int c;
      a = dq[i]; b = rq[i];
      c = C_NONE;
      if (a.pc != b.pc) c = C_PC;
      else if (a.inst != b.inst) c = C_INST;
      else if (a.wr && (a.rd != 0 || b.rd != 0) && a.rd != b.rd) c = C_RD;
      else if (a.wr && (a.rd != 0 || b.rd != 0) && a.data != b.data) c = C_DATA;
      e_commits = i + 1;
      if (c != C_NONE) begin
        e_cause = c; e_pc = a.pc; e_mis = 1;
        return;
      end
      if (a.inst == EBREAK) begin
        e_pass = 1;
        return;
      end
    end
  endtask

  task automatic check_outcome(input string tag, input int e_pass, input int e_cause,
                               input logic [31:0] e_pc, input int e_mis, input int e_commits);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_pass"}, 64'(pass), 64'(e_pass));
    chk({tag, "_fail"}, 64'(fail), 64'(e_pass == 0));
    chk({tag, "_cause"}, 64'(cause), 64'(e_cause));
    chk({tag, "_failpc"}, 64'(fpc), 64'(e_pc));
    chk({tag, "_mis"}, 64'(mis), 64'(e_mis));
    chk({tag, "_commits"}, 64'(commits), 64'(e_commits));
  endtask

  initial begin
    int ep, ec, em, en_c, n, k, m;
    logic [31:0] epc;
    rec_t tmp, tmp2;

    rst = 1'b1; en = 1'b0; d_v = 1'b0; r_v = 1'b0;
    d_pc = 0; d_inst = 0; d_wr = 0; d_rd = 0; d_data = 0;
    r_pc = 0; r_inst = 0; r_wr = 0; r_rd = 0; r_data = 0;
    rst2 = 1'b1; en2 = 1'b0; dv2 = 1'b0; rv2 = 1'b0;

    // Reset state
    do_reset();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cause", 64'(cause), 64'd0);
    chk("rst_mis", 64'(mis), 64'd0);
    chk("rst_commits", 64'(commits), 64'd0);
    chk("rst_dready", 64'(d_rdy), 64'd1);
    chk("rst_rready", 64'(r_rdy), 64'd1);
    $display("txn reset: done=%0d ready=%0d/%0d", done, d_rdy, r_rdy);

    // Identical 5 commits, with DRAIN lasting 2 cycles after the ebreak compare
    build_stream(5);
    drive(0);
    step();
    step();
    chk("ident_drain_done", 64'(done), 64'd0);
    step();
    check_outcome("ident", 1, C_NONE, 32'd0, 0, 5);
    $display("txn identical5: pass=%0d commits=%0d", pass, commits);

    // Reference leads the DUT by 4 cycles
    do_reset();
    build_stream(6);
    drive(1);
    wait_done();
    check_outcome("lead4", 1, C_NONE, 32'd0, 0, 6);
    $display("txn refleads4: pass=%0d commits=%0d", pass, commits);

    // Data mismatch on commit 3 (pc 0x8, x5): result one cycle after the pop
    do_reset();
    en = 1'b1;
    put_d(mk(32'h0, 32'h13, 1'b1, 5'd1, 32'd1)); put_r(mk(32'h0, 32'h13, 1'b1, 5'd1, 32'd1)); step();
    put_d(mk(32'h4, 32'h93, 1'b1, 5'd2, 32'd2)); put_r(mk(32'h4, 32'h93, 1'b1, 5'd2, 32'd2)); step();
    put_d(mk(32'h8, 32'h293, 1'b1, 5'd5, 32'h55)); put_r(mk(32'h8, 32'h293, 1'b1, 5'd5, 32'h56)); step();
    d_v = 1'b0; r_v = 1'b0;
    chk("data_pre_mis", 64'(mis), 64'd0);
    chk("data_pre_fail", 64'(fail), 64'd0);
    step();
    check_outcome("data", 0, C_DATA, 32'h8, 1, 3);
    $display("txn datamismatch: cause=%0d failpc=0x%0h mis=%0d", cause, fpc, mis);

    // Data difference on an x0 write is ignored
    do_reset();
    build_stream(4);
    tmp = dq[1]; tmp.wr = 1'b1; tmp.rd = 5'd0; dq[1] = tmp;
    tmp.data = tmp.data ^ 32'hFF; rq[1] = tmp;
    drive(0);
    wait_done();
    check_outcome("x0", 1, C_NONE, 32'd0, 0, 4);
    $display("txn x0write: pass=%0d", pass);

    // Inactivity timeout 20 cycles after RUN entry
    do_reset();
    en = 1'b1;
    step();
    repeat (19) step();
    chk("to_early_fail", 64'(fail), 64'd0);
    step();
    chk("to_fail", 64'(fail), 64'd1);
    chk("to_cause", 64'(cause), 64'(C_TO));
    chk("to_failpc", 64'(fpc), 64'd0);
    $display("txn timeout: fail=%0d cause=%0d", fail, cause);

    // Push during DRAIN
    do_reset();
    en = 1'b1;
    put_d(mk(32'h0, EBREAK, 1'b0, 5'd0, 32'd0)); put_r(mk(32'h0, EBREAK, 1'b0, 5'd0, 32'd0)); step();
    d_v = 1'b0; r_v = 1'b0; step();
    put_d(mk(32'h4, 32'h13, 1'b0, 5'd0, 32'd0)); step();
    d_v = 1'b0;
    chk("post_fail", 64'(fail), 64'd1);
    chk("post_cause", 64'(cause), 64'(C_POST));
    $display("txn postebreak: cause=%0d", cause);

    // DEPTH=2 overflow, then asynchronous reset while in FAIL
    rst = 1'b1;
    step();
    rst2 = 1'b0; en2 = 1'b1;
    put_d(mk(32'h0, 32'h13, 1'b0, 5'd0, 32'd0)); d_v = 1'b0; dv2 = 1'b1;
    step();
    step();
    chk("ovf_ready_full", 64'(d_rdy2), 64'd0);
    chk("ovf_pre_fail", 64'(fail2), 64'd0);
    step();
    dv2 = 1'b0;
    chk("ovf_fail", 64'(fail2), 64'd1);
    chk("ovf_cause", 64'(cause2), 64'(C_OVF));
    chk("ovf_failpc", 64'(fpc2), 64'd0);
    rst2 = 1'b1;
    #1;
    chk("arst_fail", 64'(fail2), 64'd0);
    chk("arst_done", 64'(done2), 64'd0);
    chk("arst_cause", 64'(cause2), 64'd0);
    chk("arst_dready", 64'(d_rdy2), 64'd1);
    chk("arst_rready", 64'(r_rdy2), 64'd1);
    chk("arst_commits", 64'({commits2, mis2, pass2}), 64'd0);
    $display("txn overflow+reset: fail=%0d ready=%0d", fail2, d_rdy2);
    rst = 1'b0;

    // Randomized streams with optional injected differences
    for (int run = 0; run < 25; run++) begin
      do_reset();
      n = $urandom_range(3, 10);
      dq.delete();
      for (int i = 0; i < n; i++) begin
        tmp = mk(32'(4 * i), $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        if (tmp.inst == EBREAK) tmp.inst = tmp.inst ^ 32'h1;
        if (i == n - 1) tmp = mk(32'(4 * i), EBREAK, 1'b0, 5'd0, 32'd0);
        dq.push_back(tmp);
      end
      rq = dq;
      k = $urandom_range(0, n - 1);
      m = $urandom_range(0, 5);
      tmp = dq[k]; tmp2 = rq[k];
      case (m)
        1: tmp.pc = tmp.pc + 32'd4;
        2: tmp.inst = tmp.inst ^ (32'd1 << $urandom_range(0, 31));
        3: begin tmp.wr = 1'b1; tmp2.wr = 1'b1; tmp2.rd = 5'($urandom_range(1, 30)); tmp.rd = tmp2.rd + 5'd1; end
        4: begin tmp.wr = 1'b1; tmp2.wr = 1'b1; tmp2.rd = 5'($urandom_range(1, 31)); tmp.rd = tmp2.rd;
                 tmp.data = tmp2.data ^ 32'h1; end
        5: begin tmp.wr = 1'b1; tmp2.wr = 1'b1; tmp.rd = 5'd0; tmp2.rd = 5'd0;
                 tmp.data = tmp2.data ^ 32'hFF; end
        default: ;
      endcase
      dq[k] = tmp; rq[k] = tmp2;
      predict(ep, ec, epc, em, en_c);
      drive(2);
      wait_done();
      check_outcome($sformatf("rnd%0d", run), ep, ec, epc, em, en_c);
      $display("txn random%0d: n=%0d inject=%0d@%0d pass=%0d cause=%0d commits=%0d",
               run, n, m, k, pass, cause, commits);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
